bcd_sec_timer: RTL and testbench
================================

BCD_SEC_TIMER -- requirements
Module: bcd_sec_timer

Interface
REQ-001 The block SHALL have parameter MAX_TENS, default 5, the highest tens digit before wrap.
REQ-002 The block SHALL have parameter MAX_ONES, default 9, the highest ones digit before wrap.
REQ-003 Port clock, input, 1 bit: the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port tick, input, 1 bit: count-enable pulse, one clock cycle wide, nominally 1 Hz, synchronous to clock.
REQ-006 Port start_stop, input, 1 bit: raw pushbutton level; a rising edge toggles run/pause.
REQ-007 Port clear, input, 1 bit: synchronous clear of the count, active-high.
REQ-008 Port down, input, 1 bit: 0 = count up, 1 = count down; sampled on each tick.
REQ-009 Port Q_L, output, 4 bits: BCD tens digit.
REQ-010 Port Q_R, output, 4 bits: BCD ones digit.
REQ-011 Port running, output, 1 bit: high while in state RUN.
REQ-012 Port wrap, output, 1 bit: one-cycle pulse when the count wraps in either direction.

Function
REQ-013 start_stop SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector; toggle = sync & ~sync_d.
REQ-014 The latency from a start_stop rise to a change in running SHALL be exactly 3 clock edges.
REQ-015 The state machine SHALL have two states, STOP and RUN; a toggle SHALL move STOP->RUN and RUN->STOP; there SHALL be no other transitions.
REQ-016 running SHALL be registered and equal to (state == RUN).
REQ-017 In RUN, with tick=1 and down=0: Q_R SHALL increment; when Q_R==MAX_ONES, Q_R->0 and Q_L increments.
REQ-018 In RUN, with tick=1 and down=0, at count MAX_TENS:MAX_ONES the count SHALL go to 0:0 and wrap=1 for that cycle.
REQ-019 In RUN, with tick=1 and down=1: Q_R SHALL decrement; when Q_R==0, Q_R->MAX_ONES and Q_L decrements.
REQ-020 In RUN, with tick=1 and down=1, at count 0:0 the count SHALL go to MAX_TENS:MAX_ONES and wrap=1.
REQ-021 A tick in STOP SHALL be ignored: count held, wrap=0.
REQ-022 With tick=0 the count SHALL hold in all states.
REQ-023 clear=1 SHALL force Q_L=0, Q_R=0, wrap=0 on the next edge, override any tick in the same cycle, and leave state unchanged.
REQ-024 When a toggle and a tick occur in the same cycle, the tick SHALL be evaluated against the pre-toggle state: RUN->STOP still counts that tick; STOP->RUN does not.
REQ-025 Q_L SHALL never exceed MAX_TENS and Q_R SHALL never exceed MAX_ONES; digit arithmetic SHALL be 4-bit with no binary carry beyond BCD.
REQ-026 wrap SHALL be registered and high for exactly one cycle per wrap event.
REQ-027 Q_L, Q_R, running and wrap SHALL all be driven directly from flops.

Reset
REQ-028 When reset=0, asynchronously: Q_L=0, Q_R=0, state=STOP, running=0, wrap=0, and synchronizer/edge flops=0.
REQ-029 Reset asserted mid-RUN SHALL abort counting immediately; after release the block SHALL stay in STOP until a new start_stop rise.
REQ-030 A start_stop held high through reset release SHALL NOT produce a toggle; only a subsequent rise toggles.

Verification
REQ-031 Rise start_stop, then 65 ticks, down=0 -> running=1 after 3 edges; count passes 5:9 -> 0:0 with a single wrap pulse; final count 0:5.
REQ-032 From 0:0 in RUN, down=1, 1 tick -> count 5:9, wrap=1 for one cycle; next tick -> 5:8, wrap=0.
REQ-033 In STOP, 10 ticks -> count unchanged, running=0, wrap=0.
REQ-034 At count 5:9 in RUN, clear and tick in the same cycle -> count 0:0, wrap=0, running stays 1.
REQ-035 At count 0:9 in RUN, toggle edge coincident with tick -> count 1:0, running=0; further ticks ignored.
REQ-036 Drive reset low mid-count at 3:4 -> outputs 0 immediately, before the next clock edge; with start_stop held high across release, running stays 0.

Source files
------------

// File: rtl/bcd_sec_timer.sv
// ============================================================================
// bcd_sec_timer : two-digit BCD up/down seconds timer with run/pause button
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_sec_timer #(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       down,
  output logic [3:0] Q_L,
  output logic [3:0] Q_R,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] TENS_TOP = 4'(MAX_TENS);
  localparam logic [3:0] ONES_TOP = 4'(MAX_ONES);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  state_t     state;
  logic       sync_meta;
  logic       sync_lvl;
  logic       sync_dly;
  logic [1:0] rel_pipe;
  logic       armed;
  logic       toggle;

  // A button held through reset release must not look like a rise, so edges
  // are only honoured once a genuine low level has been synchronized.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
      sync_dly  <= 1'b0;
      rel_pipe  <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_meta <= start_stop;
      sync_lvl  <= sync_meta;
      sync_dly  <= sync_lvl;
      rel_pipe  <= {rel_pipe[0], 1'b1};
      armed     <= armed | (rel_pipe[1] & ~sync_lvl);
    end
  end

  assign toggle = sync_lvl & ~sync_dly & armed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= STOP;
      running <= 1'b0;
    end else begin
      case (state)
        STOP: if (toggle) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (toggle) begin
          state   <= STOP;
          running <= 1'b0;
        end
        default: begin
          state   <= STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Counting looks at the current state, so a tick coinciding with a toggle
  // is judged against the state before the toggle takes effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Q_L  <= 4'd0;
      Q_R  <= 4'd0;
      wrap <= 1'b0;
    end else if (clear) begin
      Q_L  <= 4'd0;
      Q_R  <= 4'd0;
      wrap <= 1'b0;
    end else if (state == RUN && tick) begin
      wrap <= 1'b0;
      if (!down) begin
        if (Q_R >= ONES_TOP) begin
          Q_R <= 4'd0;
          if (Q_L >= TENS_TOP) begin
            Q_L  <= 4'd0;
            wrap <= 1'b1;
          end else begin
            Q_L <= Q_L + 4'd1;
          end
        end else begin
          Q_R <= Q_R + 4'd1;
        end
      end else begin
        if (Q_R == 4'd0) begin
          Q_R <= ONES_TOP;
          if (Q_L == 4'd0) begin
            Q_L  <= TENS_TOP;
            wrap <= 1'b1;
          end else begin
            Q_L <= Q_L - 4'd1;
          end
        end else begin
          Q_R <= Q_R - 4'd1;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_sec_timer.sv
// ============================================================================
// tb_bcd_sec_timer : directed self-checking bench for bcd_sec_timer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bcd_sec_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       down = 1'b0;
  logic [3:0] Q_L;
  logic [3:0] Q_R;
  logic       running;
  logic       wrap;

  int n_compared = 0;
  int n_mismatched = 0;
  int wrap_seen;

  bcd_sec_timer #(.MAX_TENS(5), .MAX_ONES(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .down       (down),
    .Q_L        (Q_L),
    .Q_R        (Q_R),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] cnt();
    return {Q_L, Q_R};
  endfunction

  initial begin
    // asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    check("reset_count", cnt(), 8'h00);
    check("reset_running", {7'd0, running}, 8'd0);
    check("reset_wrap", {7'd0, wrap}, 8'd0);
    edge_step();
    edge_step();
    reset = 1'b1;
    repeat (3) edge_step();

    // start: running changes on the third edge; tick on that edge is ignored
    start_stop = 1'b1;
    edge_step();
    edge_step();
    check("start_lat2", {7'd0, running}, 8'd0);
    tick = 1'b1;
    edge_step();
    check("start_lat3", {7'd0, running}, 8'd1);
    check("start_tick_ignored", cnt(), 8'h00);
    start_stop = 1'b0;

    // 65 up ticks: one wrap at 5:9 -> 0:0, ending at 0:5
    wrap_seen = 0;
    for (int i = 1; i <= 65; i++) begin
      tick = 1'b1;
      edge_step();
      if (wrap) wrap_seen++;
      if (i == 59) check("up_59", cnt(), 8'h59);
      if (i == 60) begin
        check("up_wrap_cnt", cnt(), 8'h00);
        check("up_wrap_pulse", {7'd0, wrap}, 8'd1);
      end
    end
    tick = 1'b0;
    check("up_final", cnt(), 8'h05);
    check("up_wrap_count", 8'(wrap_seen), 8'd1);
    edge_step();
    check("hold_no_tick", cnt(), 8'h05);
    check("hold_wrap_low", {7'd0, wrap}, 8'd0);

    // clear to 0:0 in RUN, then count down through the wrap
    clear = 1'b1;
    edge_step();
    clear = 1'b0;
    check("clear_cnt", cnt(), 8'h00);
    check("clear_running", {7'd0, running}, 8'd1);
    down = 1'b1;
    tick = 1'b1;
    edge_step();
    check("down_wrap_cnt", cnt(), 8'h59);
    check("down_wrap_pulse", {7'd0, wrap}, 8'd1);
    edge_step();
    check("down_next_cnt", cnt(), 8'h58);
    check("down_next_wrap", {7'd0, wrap}, 8'd0);

    // back up to 5:9, then clear overrides a coincident tick
    down = 1'b0;
    edge_step();
    check("up_to_59", cnt(), 8'h59);
    clear = 1'b1;
    edge_step();
    clear = 1'b0;
    check("clear_tick_cnt", cnt(), 8'h00);
    check("clear_tick_wrap", {7'd0, wrap}, 8'd0);
    check("clear_tick_run", {7'd0, running}, 8'd1);

    // to 0:9, then a stop toggle coincident with a tick still counts it
    repeat (9) edge_step();
    tick = 1'b0;
    check("at_09", cnt(), 8'h09);
    start_stop = 1'b1;
    edge_step();
    edge_step();
    tick = 1'b1;
    edge_step();
    start_stop = 1'b0;
    check("stop_tick_cnt", cnt(), 8'h10);
    check("stop_running", {7'd0, running}, 8'd0);

    // ticks in STOP are ignored
    wrap_seen = 0;
    repeat (10) begin
      edge_step();
      if (wrap) wrap_seen++;
    end
    tick = 1'b0;
    check("stop_hold_cnt", cnt(), 8'h10);
    check("stop_hold_run", {7'd0, running}, 8'd0);
    check("stop_hold_wrap", 8'(wrap_seen), 8'd0);

    // run again to 3:4, then reset mid-count with the button held
    start_stop = 1'b1;
    repeat (3) edge_step();
    start_stop = 1'b0;
    check("restart_run", {7'd0, running}, 8'd1);
    tick = 1'b1;
    repeat (24) edge_step();
    tick = 1'b0;
    check("at_34", cnt(), 8'h34);
    start_stop = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_rst_cnt", cnt(), 8'h00);
    check("async_rst_run", {7'd0, running}, 8'd0);
    edge_step();
    reset = 1'b1;
    repeat (6) edge_step();
    check("held_release_run", {7'd0, running}, 8'd0);

    // a fresh rise after the release does toggle
    start_stop = 1'b0;
    repeat (4) edge_step();
    start_stop = 1'b1;
    edge_step();
    edge_step();
    check("fresh_rise_lat2", {7'd0, running}, 8'd0);
    edge_step();
    check("fresh_rise_run", {7'd0, running}, 8'd1);
    check("fresh_rise_cnt", cnt(), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
